// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the 640x480@60 Hz raster generator: default porch/sync
//   geometry, derived totals and sync bounds, counter width and the colour-bar
//   lookup used by the optional test pattern (VGA_TEST_PATTERN_EN).
package vga_timing_pkg;

    localparam int unsigned CNT_W        = 10;

    localparam int unsigned DEF_CLK_DIV  = 2;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    localparam int unsigned NUM_BARS     = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c.r = {8{~idx[1]}};
        c.g = {8{~idx[2]}};
        c.b = {8{~idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis: wrap counter over ACTIVE+FP+SYNC+BP positions with decode
//   of the value it will hold after the current edge, so the parent can register
//   sync/active in the same edge that moves the counter.
//   clk_i, rst_ni    : clock, asynchronous active-low reset (count -> last)
//   clr_i            : synchronous restart to the last position
//   step_i           : advance by one on this edge
//   cnt_o            : registered position
//   wrap_o           : step_i while at the last position
//   sync_n_nxt_o     : active-low sync decode of the next position
//   active_nxt_o     : visible-region decode of the next position
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sync_n_nxt_o,
    output logic             active_nxt_o
);

    localparam int unsigned      TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap_o = step_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = LAST;
        end else if (wrap_o) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
        end
        sync_n_nxt_o = !((cnt_d >= SYNC_START) && (cnt_d < SYNC_END));
        active_nxt_o = (cnt_d < ACTIVE_END);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60 Hz raster timing from CLOCK_50: pixel enable, H/V counters,
//   syncs, blank, line/frame markers and the DAC pixel clock. Every output is a
//   flop on CLOCK_50 (VGA_SYNC_N is tied low).
//   CLOCK_50, RESET_N (async, active-low), EN (sync run enable, low = restart)
//   PIX_TICK, H_CNT, V_CNT, ACTIVE, LINE_START, FRAME_START
//   VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, VGA_R/G/B
//   Build option: define VGA_TEST_PATTERN_EN for 8 vertical colour bars on
//   VGA_R/G/B; otherwise those ports are constant 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             EN,
    output logic             PIX_TICK,
    output logic [CNT_W-1:0] H_CNT,
    output logic [CNT_W-1:0] V_CNT,
    output logic             ACTIVE,
    output logic             LINE_START,
    output logic             FRAME_START,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic             VGA_CLK,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B
);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic             clr;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_step;
    logic             pix_tick_q, pix_tick_d;
    logic             vga_clk_q, vga_clk_d;
    logic             hs_q, vs_q, active_q, line_start_q, frame_start_q;
    logic             active_d, line_start_d, frame_start_d;

    logic             h_wrap, h_sync_n_nxt, h_active_nxt;
    logic             v_wrap, v_sync_n_nxt, v_active_nxt;

    assign clr = !EN;

    // The counters move on the edge that ends a tick cycle; tick/pixel-clock
    // flops are loaded from the next divider value so they line up with it.
    always_comb begin
        pix_step = !clr && (div_q == DIV_LAST);
        div_d    = div_q + 1'b1;
        if (clr || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
        pix_tick_d    = (div_d == DIV_LAST);
        vga_clk_d     = (div_d >= DIV_HALF);
        active_d      = h_active_nxt && v_active_nxt;
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk_i        (CLOCK_50),
        .rst_ni       (RESET_N),
        .clr_i        (clr),
        .step_i       (pix_step),
        .cnt_o        (H_CNT),
        .wrap_o       (h_wrap),
        .sync_n_nxt_o (h_sync_n_nxt),
        .active_nxt_o (h_active_nxt)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk_i        (CLOCK_50),
        .rst_ni       (RESET_N),
        .clr_i        (clr),
        .step_i       (h_wrap),
        .cnt_o        (V_CNT),
        .wrap_o       (v_wrap),
        .sync_n_nxt_o (v_sync_n_nxt),
        .active_nxt_o (v_active_nxt)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            vga_clk_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= pix_tick_d;
            vga_clk_q     <= vga_clk_d;
            hs_q          <= h_sync_n_nxt;
            vs_q          <= v_sync_n_nxt;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PIX_TICK    = pix_tick_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign ACTIVE      = active_q;
    assign VGA_BLANK_N = active_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;
    assign VGA_SYNC_N  = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

    logic [CNT_W-1:0] h_nxt;
    logic [2:0]       bar_idx;
    rgb_t             rgb_q, rgb_d;

    // Column the horizontal counter will hold after this edge, rebuilt here
    // so the colour register stays aligned with H_CNT/VGA_BLANK_N.
    always_comb begin
        h_nxt = H_CNT;
        if (h_wrap) begin
            h_nxt = '0;
        end else if (pix_step) begin
            h_nxt = H_CNT + 1'b1;
        end
        bar_idx = 3'(h_nxt / CNT_W'(BAR_W));
        rgb_d   = active_d ? bar_colour(bar_idx) : '0;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign VGA_R = rgb_q.r;
    assign VGA_G = rgb_q.g;
    assign VGA_B = rgb_q.b;
`else
    assign VGA_R = '0;
    assign VGA_G = '0;
    assign VGA_B = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Instance A uses the default 640x480 timing; instance B uses a shrunken
//   raster so whole frames and mid-frame resets fit in a short run.
module tb_vga_timing_gen;

    localparam int unsigned D = 2;

    localparam int unsigned AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int unsigned AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
    localparam int unsigned BHA = 16,  BHF = 2,  BHS = 4,  BHB = 3;
    localparam int unsigned BVA = 6,   BVF = 2,  BVS = 2,  BVB = 3;
    localparam int unsigned BHT = BHA + BHF + BHS + BHB;
    localparam int unsigned BVT = BVA + BVF + BVS + BVB;

    typedef struct packed {
        logic       tick;
        logic [9:0] h;
        logic [9:0] v;
        logic       act;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic       sync_n;
        logic       vclk;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } obs_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a = 1'b0, en_a = 1'b1, rst_b = 1'b0, en_b = 1'b1;

    logic       a_tick, a_act, a_ls, a_fs, a_hs, a_vs, a_bn, a_sn, a_vclk;
    logic [9:0] a_h, a_v;
    logic [7:0] a_r, a_g, a_b;
    logic       b_tick, b_act, b_ls, b_fs, b_hs, b_vs, b_bn, b_sn, b_vclk;
    logic [9:0] b_h, b_v;
    logic [7:0] b_r, b_g, b_b;

    vga_timing_gen u_a (
        .CLOCK_50 (clk), .RESET_N (rst_a), .EN (en_a),
        .PIX_TICK (a_tick), .H_CNT (a_h), .V_CNT (a_v), .ACTIVE (a_act),
        .LINE_START (a_ls), .FRAME_START (a_fs), .VGA_HS (a_hs), .VGA_VS (a_vs),
        .VGA_BLANK_N (a_bn), .VGA_SYNC_N (a_sn), .VGA_CLK (a_vclk),
        .VGA_R (a_r), .VGA_G (a_g), .VGA_B (a_b)
    );

    vga_timing_gen #(
        .CLK_DIV (D),
        .H_ACTIVE (BHA), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
        .V_ACTIVE (BVA), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB)
    ) u_b (
        .CLOCK_50 (clk), .RESET_N (rst_b), .EN (en_b),
        .PIX_TICK (b_tick), .H_CNT (b_h), .V_CNT (b_v), .ACTIVE (b_act),
        .LINE_START (b_ls), .FRAME_START (b_fs), .VGA_HS (b_hs), .VGA_VS (b_vs),
        .VGA_BLANK_N (b_bn), .VGA_SYNC_N (b_sn), .VGA_CLK (b_vclk),
        .VGA_R (b_r), .VGA_G (b_g), .VGA_B (b_b)
    );

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;
    obs_t        exp_q[$];
    logic [33:0] pat_q[$];

    // Expected outputs after the e-th rising edge following a restart
    // (e = 0 is the restart state itself).
    function automatic obs_t model(input int unsigned e,
                                   input int unsigned ha, input int unsigned hf,
                                   input int unsigned hsw, input int unsigned hb,
                                   input int unsigned va, input int unsigned vf,
                                   input int unsigned vsw, input int unsigned vb);
        obs_t m;
        int unsigned n, ht, vt, h, v, bi;
        m  = '0;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        n  = e / D;
        if (n == 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            h = (n - 1) % ht;
            v = ((n - 1) / ht) % vt;
        end
        m.tick    = ((e % D) == D - 1);
        m.h       = 10'(h);
        m.v       = 10'(v);
        m.act     = (h < ha) && (v < va);
        m.blank_n = m.act;
        m.hs      = !((h >= ha + hf) && (h < ha + hf + hsw));
        m.vs      = !((v >= va + vf) && (v < va + vf + vsw));
        m.sync_n  = 1'b0;
        m.vclk    = ((e % D) >= D / 2);
        m.ls      = (n >= 1) && ((e % D) == 0) && (h == 0);
        m.fs      = m.ls && (v == 0);
`ifdef VGA_TEST_PATTERN_EN
        if (m.act) begin
            bi  = h / (ha / 8);
            m.r = ((bi >> 1) & 1) != 0 ? 8'h00 : 8'hFF;
            m.g = ((bi >> 2) & 1) != 0 ? 8'h00 : 8'hFF;
            m.b = (bi & 1) != 0        ? 8'h00 : 8'hFF;
        end
`else
        bi = 0;
`endif
        return m;
    endfunction

    function automatic obs_t model_a(input int unsigned e);
        return model(e, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB);
    endfunction

    function automatic obs_t model_b(input int unsigned e);
        return model(e, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB);
    endfunction

    function automatic obs_t sample_a();
        return {a_tick, a_h, a_v, a_act, a_ls, a_fs, a_hs, a_vs, a_bn, a_sn, a_vclk, a_r, a_g, a_b};
    endfunction

    function automatic obs_t sample_b();
        return {b_tick, b_h, b_v, b_act, b_ls, b_fs, b_hs, b_vs, b_bn, b_sn, b_vclk, b_r, b_g, b_b};
    endfunction

    task automatic restart_a();
        @(negedge clk); rst_a = 1'b0; en_a = 1'b1;
        @(negedge clk); rst_a = 1'b1;
    endtask

    task automatic restart_b();
        @(negedge clk); rst_b = 1'b0; en_b = 1'b1;
        @(negedge clk); rst_b = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, ex;
        @(negedge clk); rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model_a(0));
            exp_q.push_back(model_b(0));
            @(posedge clk); #1;
            got = sample_a(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL reset_a got=%h exp=%h", got, ex); end
            got = sample_b(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL reset_b got=%h exp=%h", got, ex); end
        end
        @(negedge clk); rst_a = 1'b1; rst_b = 1'b1;
        for (int unsigned e = 1; e <= 6; e++) begin
            exp_q.push_back(model_a(e));
            exp_q.push_back(model_b(e));
            @(posedge clk); #1;
            got = sample_a(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL release_a e=%0d got=%h exp=%h", e, got, ex); end
            got = sample_b(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL release_b e=%0d got=%h exp=%h", e, got, ex); end
            if (e == 2) begin
                n_vec++;
                if (!(a_h == 10'd0 && a_v == 10'd0 && a_fs === 1'b1 && a_bn === 1'b1)) begin
                    n_mis++;
                    $display("FAIL first_pixel got h=%0d v=%0d fs=%b bn=%b exp h=0 v=0 fs=1 bn=1", a_h, a_v, a_fs, a_bn);
                end
            end
        end
    endtask

    task automatic test_line();
        obs_t got, ex;
        int unsigned hs_low, ls_first, ls_second, bn_fall_h;
        logic        prev_bn, seen_fall;
        hs_low = 0; ls_first = 0; ls_second = 0; bn_fall_h = 0;
        prev_bn = 1'b0; seen_fall = 1'b0;
        restart_a();
        for (int unsigned e = 1; e <= 3300; e++) begin
            exp_q.push_back(model_a(e));
            @(posedge clk); #1;
            got = sample_a(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin
                n_mis++;
                $display("FAIL line e=%0d got h=%0d v=%0d bits=%h exp h=%0d v=%0d bits=%h", e, got.h, got.v, got, ex.h, ex.v, ex);
            end
            if (e >= 2 && e <= 1601 && a_hs === 1'b0) hs_low++;
            if (a_ls === 1'b1) begin
                if (ls_first == 0) ls_first = e;
                else if (ls_second == 0) ls_second = e;
            end
            if (!seen_fall && prev_bn === 1'b1 && a_bn === 1'b0) begin
                seen_fall = 1'b1;
                bn_fall_h = a_h;
            end
            prev_bn = a_bn;
        end
        n_vec++;
        if (hs_low != 192) begin n_mis++; $display("FAIL hs_width got=%0d exp=192", hs_low); end
        n_vec++;
        if (ls_second - ls_first != 1600) begin
            n_mis++; $display("FAIL line_period got=%0d exp=1600", ls_second - ls_first);
        end
        n_vec++;
        if (!seen_fall || bn_fall_h != 640) begin
            n_mis++; $display("FAIL blank_edge got h=%0d seen=%b exp h=640", bn_fall_h, seen_fall);
        end
    endtask

    task automatic test_frame();
        obs_t got, ex;
        int unsigned vs_low, fs_first, fs_second;
        vs_low = 0; fs_first = 0; fs_second = 0;
        restart_b();
        for (int unsigned e = 1; e <= 2 * BHT * BVT * D + 10; e++) begin
            exp_q.push_back(model_b(e));
            @(posedge clk); #1;
            got = sample_b(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin
                n_mis++;
                $display("FAIL frame e=%0d got h=%0d v=%0d bits=%h exp h=%0d v=%0d bits=%h", e, got.h, got.v, got, ex.h, ex.v, ex);
            end
            if (e >= 2 && e < 2 + BHT * BVT * D && b_vs === 1'b0) vs_low++;
            if (b_fs === 1'b1) begin
                if (fs_first == 0) fs_first = e;
                else if (fs_second == 0) fs_second = e;
            end
        end
        n_vec++;
        if (vs_low != BVS * BHT * D) begin
            n_mis++; $display("FAIL vs_width got=%0d exp=%0d", vs_low, BVS * BHT * D);
        end
        n_vec++;
        if (fs_second - fs_first != BHT * BVT * D) begin
            n_mis++; $display("FAIL frame_period got=%0d exp=%0d", fs_second - fs_first, BHT * BVT * D);
        end
    endtask

    task automatic test_async_reset();
        obs_t got, ex;
        int unsigned tgt_a, tgt_b;
        tgt_a = D * (1 + 300);
        tgt_b = D * (1 + 7 * BHT + 12);
        restart_a();
        for (int unsigned e = 1; e <= tgt_a; e++) begin
            exp_q.push_back(model_a(e));
            @(posedge clk); #1;
            got = sample_a(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL run_a e=%0d got=%h exp=%h", e, got, ex); end
        end
        #5; rst_a = 1'b0;
        exp_q.push_back(model_a(0));
        #1;
        got = sample_a(); ex = exp_q.pop_front(); n_vec++;
        if (got !== ex) begin n_mis++; $display("FAIL async_rst_a got=%h exp=%h", got, ex); end
        @(negedge clk); rst_a = 1'b1;
        for (int unsigned e = 1; e <= 6; e++) begin
            exp_q.push_back(model_a(e));
            @(posedge clk); #1;
            got = sample_a(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL rerun_a e=%0d got=%h exp=%h", e, got, ex); end
        end

        restart_b();
        for (int unsigned e = 1; e <= tgt_b; e++) begin
            exp_q.push_back(model_b(e));
            @(posedge clk); #1;
            got = sample_b(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL run_b e=%0d got=%h exp=%h", e, got, ex); end
        end
        #5; rst_b = 1'b0;
        exp_q.push_back(model_b(0));
        #1;
        got = sample_b(); ex = exp_q.pop_front(); n_vec++;
        if (got !== ex) begin n_mis++; $display("FAIL async_rst_b got=%h exp=%h", got, ex); end
        @(negedge clk); rst_b = 1'b1;
        for (int unsigned e = 1; e <= 6; e++) begin
            exp_q.push_back(model_b(e));
            @(posedge clk); #1;
            got = sample_b(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL rerun_b e=%0d got=%h exp=%h", e, got, ex); end
        end
    endtask

    task automatic test_enable();
        obs_t got, ex;
        restart_a();
        for (int unsigned e = 1; e <= 400; e++) begin
            exp_q.push_back(model_a(e));
            @(posedge clk); #1;
            got = sample_a(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL en_run e=%0d got=%h exp=%h", e, got, ex); end
        end
        @(negedge clk); en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(model_a(0));
            @(posedge clk); #1;
            got = sample_a(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL en_low i=%0d got=%h exp=%h", i, got, ex); end
        end
        @(negedge clk); en_a = 1'b1;
        for (int unsigned e = 1; e <= 6; e++) begin
            exp_q.push_back(model_a(e));
            @(posedge clk); #1;
            got = sample_a(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin n_mis++; $display("FAIL en_rise e=%0d got=%h exp=%h", e, got, ex); end
        end
    endtask

    task automatic test_pattern();
        logic [33:0] got, ex;
        logic [9:0]  pts   [4];
        logic [23:0] cols  [4];
        pts = '{10'd0, 10'd80, 10'd600, 10'd700};
`ifdef VGA_TEST_PATTERN_EN
        cols = '{24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'h000000};
`else
        cols = '{24'h000000, 24'h000000, 24'h000000, 24'h000000};
`endif
        restart_a();
        for (int unsigned e = 1; e <= D * (1 + 700); e++) begin
            for (int k = 0; k < 4; k++) begin
                if (e == D * (1 + int'(pts[k]))) pat_q.push_back({pts[k], cols[k]});
            end
            @(posedge clk); #1;
            if (pat_q.size() != 0) begin
                got = {a_h, a_r, a_g, a_b};
                ex  = pat_q.pop_front();
                n_vec++;
                if (got !== ex) begin
                    n_mis++;
                    $display("FAIL pattern got h=%0d rgb=%h exp h=%0d rgb=%h", got[33:24], got[23:0], ex[33:24], ex[23:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_async_reset();
        test_enable();
        test_pattern();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
